// File: rtl/blackjack_pkg.sv
// Shared card encoding, screen geometry and scheduler types for the blackjack display.
package blackjack_pkg;

   localparam int RANK_W = 4;
   localparam int SUIT_W = 2;
   localparam int CARD_W = RANK_W + SUIT_W;
   localparam int SLOT_W = 4;
   localparam int X_W    = 8;
   localparam int Y_W    = 7;
   localparam int ORIG_W = X_W + Y_W;

   localparam logic [RANK_W-1:0] CARD_BACK_RANK = 4'd14;

   localparam int DEF_X0       = 2;
   localparam int DEF_XSTEP    = 12;
   localparam int DEF_DEALER_Y = 10;
   localparam int DEF_PLAYER_Y = 90;
   localparam int DEF_MAX_SLOT = 9;

   typedef enum logic [1:0] {
      BOOT,
      IDLE,
      ISSUE,
      BUSY
   } sched_state_t;

   typedef enum logic [1:0] {
      SRC_INIT,
      SRC_PLAYER,
      SRC_DEALER
   } cmd_src_t;

   // A face-down card keeps its suit but shows the card-back rank.
   function automatic logic [CARD_W-1:0] card_back(input logic [CARD_W-1:0] card);
      return {CARD_BACK_RANK, card[SUIT_W-1:0]};
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one that did not win last.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic advance,
   output logic gnt0,
   output logic gnt1
);

   logic last1;

   // Pick the winner from the requests and the memory of the previous winner.
   always_comb begin
      gnt0 = req0 && (!req1 || last1);
      gnt1 = req1 && (!req0 || !last1);
   end

   // Remember who won; reset pretends requester 1 won so requester 0 takes the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last1 <= 1'b1;
      end else if (advance && (gnt0 || gnt1)) begin
         last1 <= gnt1;
      end
   end

endmodule

// File: rtl/print_scheduler.sv
// Arbitrates player, dealer and screen-clear requests onto the single card printer.
module print_scheduler
   import blackjack_pkg::*;
#(
   parameter int X0       = DEF_X0,
   parameter int XSTEP    = DEF_XSTEP,
   parameter int DEALER_Y = DEF_DEALER_Y,
   parameter int PLAYER_Y = DEF_PLAYER_Y,
   parameter int MAX_SLOT = DEF_MAX_SLOT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_req,
   input  logic              p_req,
   input  logic [CARD_W-1:0] p_card,
   input  logic [SLOT_W-1:0] p_slot,
   input  logic              d_req,
   input  logic [CARD_W-1:0] d_card,
   input  logic [SLOT_W-1:0] d_slot,
   input  logic              d_hide,
   output logic              init_ack,
   output logic              p_ack,
   output logic              d_ack,
   output logic              slot_err,
   output logic              busy,
   output logic              pr_writeprint,
   output logic              pr_init,
   output logic [CARD_W-1:0] pr_card,
   output logic [ORIG_W-1:0] pr_orig,
   input  logic              pr_waitrequest
);

   sched_state_t      state;
   sched_state_t      state_next;
   cmd_src_t          cmd_src;
   logic              cmd_err;
   logic              init_pend;
   logic              init_pend_next;
   logic              init_win;
   logic              pd_grant;
   logic              gnt_p;
   logic              gnt_d;
   logic              bad_slot;
   logic [SLOT_W-1:0] sel_slot;
   logic [CARD_W-1:0] sel_card;
   logic [X_W-1:0]    sel_x;
   logic [Y_W-1:0]    sel_y;

   rr_arbiter2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .req0    (p_req),
      .req1    (d_req),
      .advance (pd_grant),
      .gnt0    (gnt_p),
      .gnt1    (gnt_d)
   );

   // Decide this cycle's grant and build the command the winner would print.
   always_comb begin
      init_win       = (state == IDLE) && (init_req || init_pend);
      pd_grant       = (state == IDLE) && !init_win && (gnt_p || gnt_d);
      sel_slot       = gnt_p ? p_slot : d_slot;
      sel_card       = gnt_p ? p_card : (d_hide ? card_back(d_card) : d_card);
      sel_x          = X_W'(X0) + X_W'(sel_slot) * X_W'(XSTEP);
      sel_y          = gnt_p ? Y_W'(PLAYER_Y) : Y_W'(DEALER_Y);
      bad_slot       = 32'(sel_slot) > MAX_SLOT;
      init_pend_next = (init_pend || (init_req && !(state == ISSUE && cmd_src == SRC_INIT)))
                       && !init_win;
   end

   // Next state and printer/ack outputs; everything is forced quiet while reset is held.
   always_comb begin
      state_next    = state;
      busy          = 1'b0;
      pr_writeprint = 1'b0;
      pr_init       = 1'b0;
      init_ack      = 1'b0;
      p_ack         = 1'b0;
      d_ack         = 1'b0;
      slot_err      = 1'b0;
      case (state)
         BOOT: begin
            pr_writeprint = 1'b1;
            pr_init       = 1'b1;
            state_next    = BUSY;
         end
         IDLE: begin
            if (init_win || pd_grant) state_next = ISSUE;
         end
         ISSUE: begin
            pr_writeprint = !cmd_err;
            pr_init       = (cmd_src == SRC_INIT);
            init_ack      = (cmd_src == SRC_INIT);
            p_ack         = (cmd_src == SRC_PLAYER);
            d_ack         = (cmd_src == SRC_DEALER);
            slot_err      = cmd_err;
            state_next    = cmd_err ? IDLE : BUSY;
         end
         BUSY: begin
            if (!pr_waitrequest) state_next = IDLE;
         end
         default: state_next = BOOT;
      endcase
      busy = (state != IDLE);
      if (rst) begin
         busy          = 1'b0;
         pr_writeprint = 1'b0;
         pr_init       = 1'b0;
         init_ack      = 1'b0;
         p_ack         = 1'b0;
         d_ack         = 1'b0;
         slot_err      = 1'b0;
      end
   end

   // State register; reset always restarts with the boot-time screen clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Capture the granted command; a bad slot leaves the printer fields on the last real card.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_src   <= SRC_INIT;
         cmd_err   <= 1'b0;
         init_pend <= 1'b0;
         pr_card   <= '0;
         pr_orig   <= '0;
      end else begin
         init_pend <= init_pend_next;
         if (init_win) begin
            cmd_src <= SRC_INIT;
            cmd_err <= 1'b0;
         end else if (pd_grant) begin
            cmd_src <= gnt_p ? SRC_PLAYER : SRC_DEALER;
            cmd_err <= bad_slot;
            if (!bad_slot) begin
               pr_card <= sel_card;
               pr_orig <= {sel_x, sel_y};
            end
         end
      end
   end

endmodule

// File: tb/tb_print_scheduler.sv
// Self-checking bench for print_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the scheduler.
module tb_print_scheduler;

   localparam int X0       = 2;
   localparam int XSTEP    = 12;
   localparam int DEALER_Y = 10;
   localparam int PLAYER_Y = 90;
   localparam int MAX_SLOT = 9;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init_req = 1'b0;
   logic        p_req = 1'b0;
   logic [5:0]  p_card = '0;
   logic [3:0]  p_slot = '0;
   logic        d_req = 1'b0;
   logic [5:0]  d_card = '0;
   logic [3:0]  d_slot = '0;
   logic        d_hide = 1'b0;
   logic        pr_waitrequest = 1'b1;
   logic        init_ack;
   logic        p_ack;
   logic        d_ack;
   logic        slot_err;
   logic        busy;
   logic        pr_writeprint;
   logic        pr_init;
   logic [5:0]  pr_card;
   logic [14:0] pr_orig;

   int vectors = 0;
   int miscompares = 0;

   // Model: what is on screen this cycle, expressed as pending work rather than states.
   bit          m_boot;
   bit          m_show;
   bit          m_err;
   int          m_src;
   bit          m_wait;
   bit          m_pend;
   int          m_last;
   logic [5:0]  m_card;
   logic [14:0] m_orig;

   bit          seen_i;
   bit          seen_p;
   bit          seen_d;
   logic [27:0] last_act;
   logic [5:0]  order;
   int          waited;

   print_scheduler #(
      .X0       (X0),
      .XSTEP    (XSTEP),
      .DEALER_Y (DEALER_Y),
      .PLAYER_Y (PLAYER_Y),
      .MAX_SLOT (MAX_SLOT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .init_req       (init_req),
      .p_req          (p_req),
      .p_card         (p_card),
      .p_slot         (p_slot),
      .d_req          (d_req),
      .d_card         (d_card),
      .d_slot         (d_slot),
      .d_hide         (d_hide),
      .init_ack       (init_ack),
      .p_ack          (p_ack),
      .d_ack          (d_ack),
      .slot_err       (slot_err),
      .busy           (busy),
      .pr_writeprint  (pr_writeprint),
      .pr_init        (pr_init),
      .pr_card        (pr_card),
      .pr_orig        (pr_orig),
      .pr_waitrequest (pr_waitrequest)
   );

   always #5 clk = ~clk;

   // Expected output bundle {init_ack,p_ack,d_ack,slot_err,busy,writeprint,init,card,orig}.
   function automatic logic [27:0] expected_outputs();
      bit live;
      live = !rst;
      return {live && m_show && m_src == 2,
              live && m_show && m_src == 0,
              live && m_show && m_src == 1,
              live && m_show && m_err,
              live && (m_boot || m_show || m_wait),
              live && (m_boot || (m_show && !m_err)),
              live && (m_boot || (m_show && m_src == 2)),
              m_card, m_orig};
   endfunction

   // Advance the model by one clock edge using the inputs presented at that edge.
   task automatic model_step();
      bit pend_next;
      int pick;
      int slot;
      if (rst) begin
         m_boot = 1; m_show = 0; m_err = 0; m_src = 0; m_wait = 0;
         m_pend = 0; m_last = 1; m_card = '0; m_orig = '0;
         return;
      end
      pend_next = m_pend || (init_req && !(m_show && m_src == 2));
      if (m_boot) begin
         m_boot = 0;
         m_wait = 1;
      end else if (m_show) begin
         m_wait = !m_err;
         m_show = 0;
      end else if (m_wait) begin
         if (!pr_waitrequest) m_wait = 0;
      end else if (init_req || m_pend) begin
         m_show = 1; m_src = 2; m_err = 0;
         pend_next = 0;
      end else if (p_req || d_req) begin
         if (p_req && d_req) pick = (m_last == 0) ? 1 : 0;
         else pick = p_req ? 0 : 1;
         m_last = pick;
         slot = (pick == 0) ? int'(p_slot) : int'(d_slot);
         m_show = 1; m_src = pick;
         m_err = (slot > MAX_SLOT);
         if (!m_err) begin
            m_orig = {8'((X0 + slot * XSTEP) % 256), 7'((pick == 0) ? PLAYER_Y : DEALER_Y)};
            if (pick == 1 && d_hide) m_card = {4'd14, d_card[1:0]};
            else m_card = (pick == 0) ? p_card : d_card;
         end
      end
      m_pend = pend_next;
   endtask

   // One clock: compare at the falling edge, then step the model at the rising edge.
   task automatic tick();
      logic [27:0] exp;
      @(negedge clk);
      last_act = {init_ack, p_ack, d_ack, slot_err, busy, pr_writeprint, pr_init, pr_card, pr_orig};
      exp = expected_outputs();
      vectors++;
      if (last_act !== exp) begin
         miscompares++;
         $display("[TB] FAIL cycle_compare t=%0t actual=%h required=%h", $time, last_act, exp);
      end
      seen_i = init_ack;
      seen_p = p_ack;
      seen_d = d_ack;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_lit(input string name, input logic [27:0] act, input logic [27:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Tick until a number of grants have been acknowledged, logging them as 2-bit codes P=1 D=2 I=3.
   task automatic collect_grants(input int want, input int limit, input bit drop, output logic [5:0] log_out);
      int got;
      got = 0;
      log_out = '0;
      for (int i = 0; i < limit && got < want; i++) begin
         tick();
         if (seen_i) begin
            log_out = {log_out[3:0], 2'd3}; got++;
            if (drop) init_req = 1'b0;
         end else if (seen_p) begin
            log_out = {log_out[3:0], 2'd1}; got++;
            if (drop) p_req = 1'b0;
         end else if (seen_d) begin
            log_out = {log_out[3:0], 2'd2}; got++;
            if (drop) d_req = 1'b0;
         end
      end
   endtask

   task automatic applyStimulus();
      pr_waitrequest = ($urandom_range(0, 2) != 0);
      init_req = ($urandom_range(0, 24) == 0);
      if ((p_req && seen_p) || !p_req) begin
         p_req  = ($urandom_range(0, 3) == 0);
         p_card = 6'($urandom);
         p_slot = 4'($urandom_range(0, 12));
      end
      if ((d_req && seen_d) || !d_req) begin
         d_req  = ($urandom_range(0, 3) == 0);
         d_card = 6'($urandom);
         d_slot = 4'($urandom_range(0, 12));
         d_hide = 1'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
   endtask

   initial begin
      @(posedge clk);
      model_step();
      #1;

      // Reset state and the unprompted boot-time clear.
      tick();
      check_lit("reset_state", last_act, 28'd0);
      rst = 1'b0;
      tick();
      check_lit("boot_init", last_act, {7'b0000111, 21'd0});
      tick();
      check_lit("boot_hold", 28'(last_act[27:21]), 28'(7'b0000100));
      pr_waitrequest = 1'b0;
      tick();
      tick();
      check_lit("boot_done_idle", 28'(last_act[23]), 28'd0);

      // Player card, slot 3.
      p_req = 1'b1; p_card = 6'h25; p_slot = 4'd3;
      tick();
      tick();
      check_lit("player_card", last_act, {7'b0100110, 6'h25, 8'd38, 7'd90});
      check_lit("model_orig_pin", 28'(m_orig), 28'({8'd38, 7'd90}));
      p_req = 1'b0;
      tick();
      check_lit("player_ack_single", 28'(last_act[26]), 28'd0);

      // Hidden dealer card, slot 1.
      d_req = 1'b1; d_hide = 1'b1; d_card = 6'h12; d_slot = 4'd1;
      tick();
      tick();
      check_lit("dealer_hidden", last_act, {7'b0010110, 6'h3A, 8'd14, 7'd10});
      check_lit("model_card_pin", 28'(m_card), 28'(6'h3A));
      d_req = 1'b0; d_hide = 1'b0;
      tick();

      // Both requesters held: alternation starting with the player.
      p_req = 1'b1; p_card = 6'h08; p_slot = 4'd2;
      d_req = 1'b1; d_card = 6'h31; d_slot = 4'd4;
      collect_grants(3, 30, 1'b0, order);
      check_lit("rr_order", 28'(order), 28'(6'b01_10_01));
      p_req = 1'b0; d_req = 1'b0;
      tick();
      tick();

      // Init, player and dealer together: init first, then the tie.
      init_req = 1'b1;
      p_req = 1'b1; p_card = 6'h1C; p_slot = 4'd5;
      d_req = 1'b1; d_card = 6'h2B; d_slot = 4'd0;
      collect_grants(3, 40, 1'b1, order);
      check_lit("init_priority", 28'(order), 28'(6'b11_10_01));
      init_req = 1'b0; p_req = 1'b0; d_req = 1'b0;
      tick();
      tick();

      // Out-of-range slot: ack plus error, nothing printed.
      p_req = 1'b1; p_card = 6'h3F; p_slot = 4'd12;
      waited = 0;
      do begin tick(); waited++; end while (!seen_p && waited < 10);
      check_lit("bad_slot_ack_wait", 28'(seen_p), 28'd1);
      check_lit("bad_slot_flags", 28'({last_act[26], last_act[24], last_act[22], last_act[21]}), 28'(4'b1100));
      check_lit("bad_slot_hold", 28'(last_act[20:0]), 28'({6'h1C, 8'd62, 7'd90}));
      p_req = 1'b0;
      tick();
      check_lit("bad_slot_idle", 28'(last_act[23]), 28'd0);

      // Reset while the printer is still busy.
      pr_waitrequest = 1'b1;
      d_req = 1'b1; d_card = 6'h05; d_slot = 4'd0;
      waited = 0;
      do begin tick(); waited++; end while (!seen_d && waited < 10);
      check_lit("busy_ack_wait", 28'(seen_d), 28'd1);
      d_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check_lit("rst_mid_busy", 28'(last_act[27:21]), 28'd0);
      tick();
      check_lit("rst_cleared", last_act, 28'd0);
      rst = 1'b0;
      tick();
      check_lit("reboot_init", last_act, {7'b0000111, 21'd0});

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
